// File: rtl/dijkstra_pkg.sv
// Shared constants, FSM encoding and the fixed 9-node weighted graph for the
// shortest-path engine.
package dijkstra_pkg;

    localparam int unsigned N_NODES  = 9;
    localparam int unsigned W_WIDTH  = 4;
    localparam int unsigned D_WIDTH  = 8;
    localparam int unsigned ID_WIDTH = 4;

    localparam logic [D_WIDTH-1:0]  INF       = '1;
    localparam logic [ID_WIDTH-1:0] LAST_NODE = ID_WIDTH'(N_NODES - 1);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StSelect,
        StRelax,
        StTrace,
        StDone
    } state_e;

    // Row u holds w(u,v) in nibble v (node 0 in the least significant nibble).
    localparam logic [N_NODES*W_WIDTH-1:0] WEIGHT_ROWS [N_NODES] = '{
        36'h000002040,
        36'h000010304,
        36'h000600030,
        36'h007050002,
        36'h030205010,
        36'h400020600,
        36'h010007000,
        36'h201030000,
        36'h020400000
    };

endpackage

// File: rtl/dijkstra_engine_if.sv
// Request/result bundle between the switch logic, the search engine and the
// renderer's distance read port.
interface dijkstra_engine_if;
    import dijkstra_pkg::*;

    logic                       start;
    logic [ID_WIDTH-1:0]        src;
    logic [ID_WIDTH-1:0]        dst;
    logic [N_NODES-1:0]         node_block;
    logic                       busy;
    logic                       done;
    logic                       unreachable;
    logic [N_NODES-1:0]         path_mask;
    logic [N_NODES-1:0]         visited;
    logic [D_WIDTH-1:0]         dist_out;
    logic [ID_WIDTH-1:0]        rd_node;
    logic [D_WIDTH-1:0]         rd_dist;

    modport master (
        output start, src, dst, node_block, rd_node,
        input  busy, done, unreachable, path_mask, visited, dist_out, rd_dist
    );

    modport slave (
        input  start, src, dst, node_block, rd_node,
        output busy, done, unreachable, path_mask, visited, dist_out, rd_dist
    );

endinterface

// File: rtl/dijkstra_engine_graph_rom.sv
// Combinational edge-weight lookup; any out-of-range id reads as "no edge".
module graph_rom
    import dijkstra_pkg::*;
(
    input  logic [ID_WIDTH-1:0] u_i,
    input  logic [ID_WIDTH-1:0] v_i,
    output logic [W_WIDTH-1:0]  w_o
);

    always_comb begin
        w_o = '0;
        if (u_i <= LAST_NODE && v_i <= LAST_NODE) begin
            w_o = WEIGHT_ROWS[u_i][v_i*W_WIDTH +: W_WIDTH];
        end
    end

endmodule

// File: rtl/dijkstra_engine.sv
// Sequential Dijkstra search over the fixed 9-node graph: one node examined per
// cycle in both the select and relax scans, then a predecessor walk for the path.
module dijkstra_engine
    import dijkstra_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    dijkstra_engine_if.slave  bus
);

    state_e                state_q;
    logic [D_WIDTH-1:0]    dist_q [N_NODES];
    logic [ID_WIDTH-1:0]   prev_q [N_NODES];
    logic [N_NODES-1:0]    visited_q;
    logic [N_NODES-1:0]    block_q;
    logic [N_NODES-1:0]    path_mask_q;
    logic [ID_WIDTH-1:0]   src_q;
    logic [ID_WIDTH-1:0]   dst_q;
    logic [ID_WIDTH-1:0]   k_q;
    logic [ID_WIDTH-1:0]   u_q;
    logic [ID_WIDTH-1:0]   cur_q;
    logic [D_WIDTH-1:0]    sel_min_q;
    logic [ID_WIDTH-1:0]   sel_idx_q;
    logic                  sel_found_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  unreach_q;
    logic [D_WIDTH-1:0]    dist_out_q;

    logic [W_WIDTH-1:0]    w_uk;
    logic                  sel_cand;
    logic [D_WIDTH-1:0]    sel_min_nx;
    logic [ID_WIDTH-1:0]   sel_idx_nx;
    logic                  sel_found_nx;
    logic [D_WIDTH:0]      relax_sum;
    logic                  relax_ok;
    logic                  req_invalid;

    graph_rom u_graph_rom (
        .u_i (u_q),
        .v_i (k_q),
        .w_o (w_uk)
    );

    // Strict less-than keeps the lowest-index node on ties and never picks INF.
    always_comb begin
        sel_cand     = !visited_q[k_q] && !block_q[k_q] && (dist_q[k_q] < sel_min_q);
        sel_min_nx   = sel_cand ? dist_q[k_q] : sel_min_q;
        sel_idx_nx   = sel_cand ? k_q : sel_idx_q;
        sel_found_nx = sel_found_q || sel_cand;
    end

    always_comb begin
        relax_sum = {1'b0, dist_q[u_q]} + {{(D_WIDTH + 1 - W_WIDTH){1'b0}}, w_uk};
        relax_ok  = (w_uk != '0) && !visited_q[k_q] && !block_q[k_q] &&
                    (relax_sum < {1'b0, dist_q[k_q]});
    end

    always_comb begin
        req_invalid = 1'b0;
        if (bus.src > LAST_NODE || bus.dst > LAST_NODE) begin
            req_invalid = 1'b1;
        end else if (bus.node_block[bus.src] || bus.node_block[bus.dst]) begin
            req_invalid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            for (int i = 0; i < N_NODES; i++) begin
                dist_q[i] <= INF;
                prev_q[i] <= '0;
            end
            visited_q   <= '0;
            block_q     <= '0;
            path_mask_q <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            k_q         <= '0;
            u_q         <= '0;
            cur_q       <= '0;
            sel_min_q   <= INF;
            sel_idx_q   <= '0;
            sel_found_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            unreach_q   <= 1'b0;
            dist_out_q  <= INF;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        src_q       <= bus.src;
                        dst_q       <= bus.dst;
                        block_q     <= bus.node_block;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        unreach_q   <= req_invalid;
                        path_mask_q <= '0;
                        state_q     <= req_invalid ? StDone : StInit;
                    end
                end
                StInit: begin
                    for (int i = 0; i < N_NODES; i++) begin
                        dist_q[i] <= (ID_WIDTH'(i) == src_q) ? '0 : INF;
                        prev_q[i] <= src_q;
                    end
                    visited_q   <= '0;
                    k_q         <= '0;
                    sel_min_q   <= INF;
                    sel_idx_q   <= '0;
                    sel_found_q <= 1'b0;
                    state_q     <= StSelect;
                end
                StSelect: begin
                    if (k_q == LAST_NODE) begin
                        k_q         <= '0;
                        sel_min_q   <= INF;
                        sel_idx_q   <= '0;
                        sel_found_q <= 1'b0;
                        cur_q       <= dst_q;
                        if (!sel_found_nx) begin
                            state_q <= StTrace;
                        end else begin
                            visited_q[sel_idx_nx] <= 1'b1;
                            u_q                   <= sel_idx_nx;
                            state_q <= (sel_idx_nx == dst_q) ? StTrace : StRelax;
                        end
                    end else begin
                        k_q         <= k_q + 1'b1;
                        sel_min_q   <= sel_min_nx;
                        sel_idx_q   <= sel_idx_nx;
                        sel_found_q <= sel_found_nx;
                    end
                end
                StRelax: begin
                    if (relax_ok) begin
                        dist_q[k_q] <= relax_sum[D_WIDTH-1:0];
                        prev_q[k_q] <= u_q;
                    end
                    if (k_q == LAST_NODE) begin
                        k_q     <= '0;
                        state_q <= StSelect;
                    end else begin
                        k_q <= k_q + 1'b1;
                    end
                end
                StTrace: begin
                    if (dist_q[dst_q] == INF) begin
                        unreach_q   <= 1'b1;
                        path_mask_q <= '0;
                        state_q     <= StDone;
                    end else begin
                        path_mask_q[cur_q] <= 1'b1;
                        if (cur_q == src_q) begin
                            state_q <= StDone;
                        end else begin
                            cur_q <= prev_q[cur_q];
                        end
                    end
                end
                StDone: begin
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    dist_out_q <= unreach_q ? INF : dist_q[dst_q];
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.unreachable = unreach_q;
    assign bus.path_mask   = path_mask_q;
    assign bus.visited     = visited_q;
    assign bus.dist_out    = dist_out_q;
    assign bus.rd_dist     = (bus.rd_node <= LAST_NODE) ? dist_q[bus.rd_node] : INF;

endmodule

// File: tb/tb_dijkstra_engine.sv
// Directed bench for dijkstra_engine: known routes on the fixed graph, blocked and
// invalid requests, exact latencies, and disturbances during a search.
module tb_dijkstra_engine;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    localparam int MAX_WAIT = 200;

    dijkstra_engine_if bus ();

    dijkstra_engine u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Leaves the bench at the falling edge right after the edge that samples start.
    task automatic do_start(input logic [3:0] s, input logic [3:0] d, input logic [8:0] blk);
        @(negedge clk);
        bus.start      = 1'b1;
        bus.src        = s;
        bus.dst        = d;
        bus.node_block = blk;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (!bus.done && n < MAX_WAIT) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic test_reset();
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.unreachable !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags: busy=%b done=%b unr=%b, want 0 0 0",
                     bus.busy, bus.done, bus.unreachable);
        end
        checks++;
        if (bus.path_mask !== 9'h000 || bus.visited !== 9'h000 || bus.dist_out !== 8'hFF) begin
            failures++;
            $display("FAIL reset_outputs: path=%h vis=%h dist=%h, want 000 000 ff",
                     bus.path_mask, bus.visited, bus.dist_out);
        end
        bus.rd_node = 4'd0;
        #1;
        checks++;
        if (bus.rd_dist !== 8'hFF) begin
            failures++;
            $display("FAIL reset_rd_dist: got %h want ff", bus.rd_dist);
        end
    endtask

    task automatic test_basic_path();
        int n;
        do_start(4'd0, 4'd8, 9'h000);
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            failures++;
            $display("FAIL basic_busy: busy=%b done=%b want 1 0", bus.busy, bus.done);
        end
        wait_done(n);
        checks++;
        if (n !== 160) begin
            failures++;
            $display("FAIL basic_latency: got %0d want 160", n);
        end
        checks++;
        if (bus.dist_out !== 8'd10 || bus.path_mask !== 9'h193 || bus.unreachable !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: dist=%0d path=%h unr=%b want 10 193 0",
                     bus.dist_out, bus.path_mask, bus.unreachable);
        end
        checks++;
        if (bus.visited !== 9'h1FF || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_visited: vis=%h busy=%b want 1ff 0", bus.visited, bus.busy);
        end
        bus.rd_node = 4'd4;
        #1;
        checks++;
        if (bus.rd_dist !== 8'd5) begin
            failures++;
            $display("FAIL basic_rd4: got %0d want 5", bus.rd_dist);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (bus.done !== 1'b1 || bus.path_mask !== 9'h193) begin
            failures++;
            $display("FAIL basic_hold: done=%b path=%h want 1 193", bus.done, bus.path_mask);
        end
    endtask

    task automatic test_tie_break();
        int n;
        do_start(4'd0, 4'd6, 9'h000);
        wait_done(n);
        checks++;
        if (n >= MAX_WAIT || bus.dist_out !== 8'd9 || bus.path_mask !== 9'h049) begin
            failures++;
            $display("FAIL tie_break: n=%0d dist=%0d path=%h want 9 049",
                     n, bus.dist_out, bus.path_mask);
        end
        checks++;
        if (bus.visited !== 9'h0FF) begin
            failures++;
            $display("FAIL tie_visited: got %h want 0ff", bus.visited);
        end
    endtask

    task automatic test_obstacles();
        int n;
        do_start(4'd0, 4'd8, 9'h050);
        wait_done(n);
        checks++;
        if (n >= MAX_WAIT || bus.dist_out !== 8'd17 || bus.path_mask !== 9'h127 ||
            bus.unreachable !== 1'b0) begin
            failures++;
            $display("FAIL obstacles: n=%0d dist=%0d path=%h unr=%b want 17 127 0",
                     n, bus.dist_out, bus.path_mask, bus.unreachable);
        end
    endtask

    task automatic test_unreachable();
        int n;
        do_start(4'd0, 4'd8, 9'h0A0);
        wait_done(n);
        checks++;
        if (n >= MAX_WAIT || bus.unreachable !== 1'b1 || bus.path_mask !== 9'h000 ||
            bus.dist_out !== 8'hFF) begin
            failures++;
            $display("FAIL unreachable: n=%0d unr=%b path=%h dist=%h want 1 000 ff",
                     n, bus.unreachable, bus.path_mask, bus.dist_out);
        end
        checks++;
        if (bus.visited !== 9'h05F) begin
            failures++;
            $display("FAIL unreach_visited: got %h want 05f", bus.visited);
        end
    endtask

    task automatic test_invalid();
        int n;
        do_start(4'd9, 4'd2, 9'h000);
        wait_done(n);
        checks++;
        if (n !== 1 || bus.unreachable !== 1'b1 || bus.path_mask !== 9'h000 ||
            bus.dist_out !== 8'hFF) begin
            failures++;
            $display("FAIL invalid_src: n=%0d unr=%b path=%h dist=%h want 1 1 000 ff",
                     n, bus.unreachable, bus.path_mask, bus.dist_out);
        end
        do_start(4'd0, 4'd8, 9'h100);
        wait_done(n);
        checks++;
        if (n !== 1 || bus.unreachable !== 1'b1 || bus.dist_out !== 8'hFF) begin
            failures++;
            $display("FAIL blocked_dst: n=%0d unr=%b dist=%h want 1 1 ff",
                     n, bus.unreachable, bus.dist_out);
        end
    endtask

    task automatic test_src_eq_dst();
        int n;
        do_start(4'd3, 4'd3, 9'h000);
        wait_done(n);
        checks++;
        if (n !== 12 || bus.dist_out !== 8'd0 || bus.path_mask !== 9'h008 ||
            bus.unreachable !== 1'b0) begin
            failures++;
            $display("FAIL src_eq_dst: n=%0d dist=%0d path=%h unr=%b want 12 0 008 0",
                     n, bus.dist_out, bus.path_mask, bus.unreachable);
        end
        bus.rd_node = 4'd3;
        #1;
        checks++;
        if (bus.rd_dist !== 8'd0) begin
            failures++;
            $display("FAIL rd_src: got %h want 00", bus.rd_dist);
        end
        bus.rd_node = 4'd4;
        #1;
        checks++;
        if (bus.rd_dist !== 8'hFF) begin
            failures++;
            $display("FAIL rd_unrelaxed: got %h want ff", bus.rd_dist);
        end
        bus.rd_node = 4'd9;
        #1;
        checks++;
        if (bus.rd_dist !== 8'hFF) begin
            failures++;
            $display("FAIL rd_out_of_range: got %h want ff", bus.rd_dist);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        do_start(4'd0, 4'd6, 9'h000);
        for (int i = 0; i < 6; i++) begin
            bus.start      = i[0];
            bus.src        = 4'd9;
            bus.dst        = 4'd1;
            bus.node_block = 9'h1FF;
            @(negedge clk);
        end
        bus.start = 1'b0;
        wait_done(n);
        checks++;
        if (n >= MAX_WAIT || bus.dist_out !== 8'd9 || bus.path_mask !== 9'h049 ||
            bus.unreachable !== 1'b0) begin
            failures++;
            $display("FAIL start_while_busy: n=%0d dist=%0d path=%h unr=%b want 9 049 0",
                     n, bus.dist_out, bus.path_mask, bus.unreachable);
        end
    endtask

    task automatic test_reset_mid_search();
        do_start(4'd0, 4'd8, 9'h000);
        repeat (14) @(negedge clk);
        checks++;
        if (bus.busy !== 1'b1 || bus.visited !== 9'h001) begin
            failures++;
            $display("FAIL pre_reset: busy=%b vis=%h want 1 001", bus.busy, bus.visited);
        end
        bus.rd_node = 4'd0;
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.visited !== 9'h000 ||
            bus.path_mask !== 9'h000 || bus.dist_out !== 8'hFF || bus.rd_dist !== 8'hFF ||
            bus.unreachable !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid: busy=%b done=%b vis=%h path=%h dist=%h rd=%h unr=%b",
                     bus.busy, bus.done, bus.visited, bus.path_mask, bus.dist_out,
                     bus.rd_dist, bus.unreachable);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_rerun_after_reset();
        int n;
        do_start(4'd0, 4'd8, 9'h000);
        wait_done(n);
        checks++;
        if (n !== 160 || bus.dist_out !== 8'd10 || bus.path_mask !== 9'h193) begin
            failures++;
            $display("FAIL rerun: n=%0d dist=%0d path=%h want 160 10 193",
                     n, bus.dist_out, bus.path_mask);
        end
        bus.rd_node = 4'd8;
        #1;
        checks++;
        if (bus.rd_dist !== 8'd10) begin
            failures++;
            $display("FAIL rerun_rd8: got %0d want 10", bus.rd_dist);
        end
    endtask

    initial begin
        checks         = 0;
        failures       = 0;
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.src        = 4'd0;
        bus.dst        = 4'd0;
        bus.node_block = 9'h000;
        bus.rd_node    = 4'd0;
        repeat (3) @(negedge clk);
        test_reset();
        reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic_path();
        test_tie_break();
        test_obstacles();
        test_unreachable();
        test_invalid();
        test_src_eq_dst();
        test_start_while_busy();
        test_reset_mid_search();
        test_rerun_after_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dijkstra_engine.md
# dijkstra_engine

Shortest-path solver core for the 9-node display graph. Sits directly upstream of the VGA renderer in the 25 MHz domain: it takes source/destination and blocked-node selections from the switch logic, runs a sequential Dijkstra search over a fixed weighted graph, and presents the result for drawing:

- path node mask
- visited mask
- total distance
- per-node distance read port

## Interface

Parameters:
- N_NODES, 9, number of graph nodes (node ids 0..8)
- W_WIDTH, 4, edge weight width; weight 0 means no edge
- D_WIDTH, 8, distance width; all-ones (8'hFF) = INF

Ports:
- clk  in  1  25 MHz pixel-domain clock; single clock
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- src  in  4  source node id
- dst  in  4  destination node id
- node_block  in  9  bit i=1: node i is an obstacle; sampled with start
- busy  out  1  search in progress
- done  out  1  result valid; held until next accepted start
- unreachable  out  1  no path exists (valid with done)
- path_mask  out  9  bit i=1: node i lies on the shortest path
- visited  out  9  nodes finalized so far; live during search
- dist_out  out  8  dist[dst]; INF if unreachable
- rd_node  in  4  display read address
- rd_dist  out  8  combinational dist[rd_node]; INF for rd_node ≥ 9

## Operation

- FSM states: IDLE, INIT, SELECT, RELAX, TRACE, DONE.
- **IDLE**
  - On start, latch src, dst and node_block.
  - If src ≥ 9, dst ≥ 9, or node_block[src] or node_block[dst] is set, go to DONE with unreachable=1, path_mask=0, dist_out=INF.
  - Otherwise go to INIT.
- **INIT** (1 cycle)
  - dist[all]=INF, dist[src]=0, prev[all]=src.
  - visited=0; blocked nodes are kept in a separate mask and treated as permanently excluded.
- **SELECT** (9 cycles, scan k=0..8)
  - Track the minimum dist over nodes that are neither visited nor blocked; ties go to the lowest index.
  - At scan end, if the minimum is INF or no candidate exists: go to TRACE.
  - Otherwise set visited[u]. If u==dst, go to TRACE; else go to RELAX.
- **RELAX** (9 cycles, scan v=0..8)
  - Condition: w(u,v)≠0, v not visited, v not blocked, and dist[u]+w(u,v) < dist[v].
  - When the condition holds: dist[v] ← sum, prev[v] ← u.
  - Sum is computed at D_WIDTH+1 bits.
  - Comparison is strict less-than, so on an equal-cost tie the earlier predecessor is kept.
  - Then return to SELECT.
- **TRACE** (one node per cycle)
  - If dist[dst]==INF: unreachable=1, path_mask=0.
  - Otherwise set cur=dst; each cycle set path_mask[cur] and step cur ← prev[cur]; the state ends after setting bit src.
  - Takes at most 9 cycles.
- **DONE**
  - done=1, busy=0, dist_out=dist[dst].
  - Go to IDLE in the next cycle; the outputs persist there.
- **src==dst**: dst is selected in the first SELECT, giving dist_out=0 and path_mask = only the src bit.
- **start while busy**: ignored.
- **reset mid-search**: immediate return to IDLE; all state cleared.

## Timing

- Reset values:
  - busy=0, done=0, unreachable=0, path_mask=0, visited=0, dist_out=8'hFF
  - dist table all INF, so rd_dist=8'hFF
- start sampled at edge E: busy=1 and done=0 from E+1.
- Latency (start edge to done rising): 1 + 18·R + 9 + T + 1 cycles, where R = RELAX passes and T = TRACE cycles.
  - Worst case ≤ 174 cycles.
  - Invalid or blocked request: done rises 1 cycle after the start edge.
- path_mask bits accumulate during TRACE. They are final only when done=1.
- visited updates on the last SELECT cycle. The renderer may show it live.
- rd_dist is combinational, with no added latency.

## Structure

- Package dijkstra_pkg holds:
  - N_NODES, W_WIDTH, D_WIDTH and INF
  - FSM state encoding
  - the 9×9 symmetric weight constant
- Undirected edges in the weight constant: 0-1:4, 0-3:2, 1-2:3, 1-4:1, 3-4:5, 3-6:7, 4-5:2, 4-7:3, 2-5:6, 6-7:1, 7-8:2, 5-8:4.
- Sub-module graph_rom: combinational w(u,v) lookup from the package constant. It returns 0 for any id ≥ 9.

## Test plan

- **Basic path**: src=0, dst=8, node_block=0 → dist_out=10, path_mask=9'h193 (0,1,4,7,8), unreachable=0, done within 174 cycles.
- **Tie-break**: src=0, dst=6 → dist_out=9, path_mask=9'h049 (0,3,6). The equal-cost route via 7 is rejected because of the strict compare.
- **Obstacles**: src=0, dst=8, node_block=9'h050 (4,6) → dist_out=17, path_mask=9'h127 (0,1,2,5,8).
- **Unreachable and invalid requests**:
  - node_block=9'h0A0 (5,7), src=0, dst=8 → unreachable=1, path_mask=0, dist_out=8'hFF.
  - src=9 → same result, with done one cycle after start.
- **src==dst**: src=dst=3 → dist_out=0, path_mask=9'h008; then rd_node=3 gives rd_dist=0.
- **Disturbances**:
  - start pulses while busy → no effect on the result.
  - reset asserted mid-RELAX → outputs return to reset values immediately.
  - A fresh 0→8 run after reset reproduces 9'h193 with dist_out=10.
